// File: rtl/addr_seqr_pkg.sv
// Shared constants and types for the address range sequencer.
// Holds the end-of-range mode codes, the direction codes and the run/halt state type.
package addr_seqr_pkg;

  localparam logic [1:0] MODE_WRAP = 2'd0;
  localparam logic [1:0] MODE_STOP = 2'd1;
  localparam logic [1:0] MODE_PING = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seqr_state_e;

endpackage

// File: rtl/addr_next_calc.sv
// Combinational next-address calculation for one accepted step.
// Inputs : address, dir, lo_bound, hi_bound, stride, mode
// Outputs: next_addr (address after the step), flip (reverse direction),
//          halt (enter HALT), evt (wrap/clamp/flip event, drives the wrapped pulse)
// The caller decides whether a step is accepted (run state, valid window, stride != 0).
module addr_next_calc
  import addr_seqr_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned STRIDE_W = 4
) (
  input  logic [ADDR_W-1:0]   address,
  input  logic                dir,
  input  logic [ADDR_W-1:0]   lo_bound,
  input  logic [ADDR_W-1:0]   hi_bound,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [1:0]          mode,
  output logic [ADDR_W-1:0]   next_addr,
  output logic                flip,
  output logic                halt,
  output logic                evt
);

  // One extra bit so carry out of the top and borrow below zero stay visible.
  logic [ADDR_W:0] addr_ext, lo_ext, hi_ext, stride_ext;
  logic [ADDR_W:0] cand_up, cand_dn;
  logic            outside, overrun_up, underrun_dn, past_end;

  assign addr_ext   = {1'b0, address};
  assign lo_ext     = {1'b0, lo_bound};
  assign hi_ext     = {1'b0, hi_bound};
  assign stride_ext = (ADDR_W + 1)'(stride);

  assign cand_up = addr_ext + stride_ext;
  assign cand_dn = addr_ext - stride_ext;

  assign outside     = (address < lo_bound) || (address > hi_bound);
  assign overrun_up  = cand_up > hi_ext;
  // A borrow sets the top bit, so it must be caught before the plain compare.
  assign underrun_dn = cand_dn[ADDR_W] || (cand_dn < lo_ext);
  assign past_end    = (dir == DIR_UP) ? overrun_up : underrun_dn;

  always_comb begin
    next_addr = address;
    flip      = 1'b0;
    halt      = 1'b0;
    evt       = 1'b0;
    if (mode == MODE_HOLD) begin
      next_addr = address;
    end else if (outside) begin
      // Re-enter the window at the bound the walk would start from.
      next_addr = (dir == DIR_DN) ? hi_bound : lo_bound;
      evt       = 1'b1;
    end else if (past_end) begin
      evt = 1'b1;
      case (mode)
        MODE_WRAP: next_addr = (dir == DIR_UP) ? lo_bound : hi_bound;
        MODE_STOP: begin
          next_addr = (dir == DIR_UP) ? hi_bound : lo_bound;
          halt      = 1'b1;
        end
        MODE_PING: begin
          next_addr = (dir == DIR_UP) ? hi_bound : lo_bound;
          flip      = 1'b1;
        end
        default: begin
          next_addr = address;
          evt       = 1'b0;
        end
      endcase
    end else begin
      next_addr = (dir == DIR_UP) ? cand_up[ADDR_W-1:0] : cand_dn[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/addr_range_seqr.sv
// Programmable-window address sequencer.
// Steps a registered address through [lo_bound, hi_bound] by stride, up or down,
// with WRAP / STOP / PINGPONG / HOLD end-of-range handling.
// Inputs : clock, reset (sync, active high), step, load, load_addr, dir_init,
//          lo_bound, hi_bound, stride, mode
// Outputs: address, dir (registered), wrapped (one-cycle event pulse),
//          done (halted in STOP mode), cfg_err (combinational lo_bound > hi_bound)
// Edge priority: reset > load > step.
module addr_range_seqr
  import addr_seqr_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned STRIDE_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                step,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic                dir_init,
  input  logic [ADDR_W-1:0]   lo_bound,
  input  logic [ADDR_W-1:0]   hi_bound,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [1:0]          mode,
  output logic [ADDR_W-1:0]   address,
  output logic                dir,
  output logic                wrapped,
  output logic                done,
  output logic                cfg_err
);

  seqr_state_e       state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              dir_q, dir_d;
  logic              wrapped_q, wrapped_d;

  logic [ADDR_W-1:0] calc_addr;
  logic              calc_flip, calc_halt, calc_evt;
  logic              step_ok;

  addr_next_calc #(
    .ADDR_W   (ADDR_W),
    .STRIDE_W (STRIDE_W)
  ) u_next_calc (
    .address   (address_q),
    .dir       (dir_q),
    .lo_bound  (lo_bound),
    .hi_bound  (hi_bound),
    .stride    (stride),
    .mode      (mode),
    .next_addr (calc_addr),
    .flip      (calc_flip),
    .halt      (calc_halt),
    .evt       (calc_evt)
  );

  assign cfg_err = lo_bound > hi_bound;
  assign step_ok = step && (state_q == ST_RUN) && !cfg_err && (stride != '0) &&
                   (mode != MODE_HOLD);

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    dir_d     = dir_q;
    wrapped_d = 1'b0;
    if (load) begin
      address_d = load_addr;
      dir_d     = dir_init;
      state_d   = ST_RUN;
    end else if (step_ok) begin
      address_d = calc_addr;
      wrapped_d = calc_evt;
      if (calc_flip) dir_d = ~dir_q;
      if (calc_halt) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      address_q <= '0;
      dir_q     <= dir_init;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      dir_q     <= dir_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign address = address_q;
  assign dir     = dir_q;
  assign wrapped = wrapped_q;
  // HALT is only ever entered from STOP mode, so done is the halt state itself.
  assign done    = (state_q == ST_HALT);

endmodule

// File: tb/tb_addr_range_seqr.sv
// Self-checking bench for addr_range_seqr: directed scenarios plus a randomized
// run compared against an integer-arithmetic reference model.
module tb_addr_range_seqr;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       step = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_addr = 8'd0;
  logic       dir_init = 1'b0;
  logic [7:0] lo_bound = 8'd0;
  logic [7:0] hi_bound = 8'd255;
  logic [3:0] stride = 4'd1;
  logic [1:0] mode = 2'd0;
  logic [7:0] address;
  logic       dir, wrapped, done, cfg_err;

  int total = 0;
  int bad = 0;

  // Reference model state: address, direction, halted, wrapped pulse.
  int m_a = 0;
  int m_d = 0;
  int m_h = 0;
  int m_w = 0;

  addr_range_seqr #(
    .ADDR_W   (8),
    .STRIDE_W (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .step      (step),
    .load      (load),
    .load_addr (load_addr),
    .dir_init  (dir_init),
    .lo_bound  (lo_bound),
    .hi_bound  (hi_bound),
    .stride    (stride),
    .mode      (mode),
    .address   (address),
    .dir       (dir),
    .wrapped   (wrapped),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  // Behavioural rules applied with plain integers at each rising edge.
  task automatic model_edge();
    int lo, hi, s, c;
    lo = int'(lo_bound);
    hi = int'(hi_bound);
    s  = int'(stride);
    if (reset) begin
      m_a = 0; m_d = int'(dir_init); m_h = 0; m_w = 0;
    end else if (load) begin
      m_a = int'(load_addr); m_d = int'(dir_init); m_h = 0; m_w = 0;
    end else begin
      m_w = 0;
      if (step && m_h == 0 && lo <= hi && s != 0 && mode != 2'd3) begin
        if (m_a < lo || m_a > hi) begin
          m_a = (m_d == 1) ? hi : lo;
          m_w = 1;
        end else begin
          c = (m_d == 1) ? m_a - s : m_a + s;
          if ((m_d == 0 && c > hi) || (m_d == 1 && c < lo)) begin
            m_w = 1;
            if (mode == 2'd0) begin
              m_a = (m_d == 1) ? hi : lo;
            end else if (mode == 2'd1) begin
              m_a = (m_d == 1) ? lo : hi;
              m_h = 1;
            end else begin
              m_a = (m_d == 1) ? lo : hi;
              m_d = 1 - m_d;
            end
          end else begin
            m_a = c;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_step();
    step = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] a, input logic d);
    load_addr = a;
    dir_init  = d;
    load      = 1'b1;
    cycle();
    load      = 1'b0;
  endtask

  task automatic set_cfg(input int lo, input int hi, input int s, input int md);
    lo_bound = 8'(lo);
    hi_bound = 8'(hi);
    stride   = 4'(s);
    mode     = 2'(md);
  endtask

  task automatic test_reset();
    dir_init = 1'b1;
    reset    = 1'b1;
    cycle();
    reset    = 1'b0;
    total++;
    if (address !== 8'd0) begin
      bad++; $display("FAIL reset_addr: got %0d expected 0", address);
    end
    total++;
    if (dir !== 1'b1) begin
      bad++; $display("FAIL reset_dir_dn: got %0b expected 1", dir);
    end
    total++;
    if (wrapped !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got wrapped=%0b done=%0b expected 0 0", wrapped, done);
    end
    dir_init = 1'b0;
    reset    = 1'b1;
    cycle();
    reset    = 1'b0;
    total++;
    if (dir !== 1'b0) begin
      bad++; $display("FAIL reset_dir_up: got %0b expected 0", dir);
    end
  endtask

  task automatic test_wrap_full();
    int pulses = 0;
    set_cfg(0, 255, 1, 0);
    dir_init = 1'b0;
    reset    = 1'b1;
    cycle();
    reset    = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      do_step();
      if (wrapped === 1'b1) pulses++;
      total++;
      if (int'(address) !== k % 256) begin
        bad++; $display("FAIL wrap_full_addr[%0d]: got %0d expected %0d", k, address, k % 256);
      end
      total++;
      if (wrapped !== (k == 256)) begin
        bad++; $display("FAIL wrap_full_pulse[%0d]: got %0b expected %0b", k, wrapped, k == 256);
      end
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL wrap_full_pulse_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_stop();
    int ea[3] = '{14, 18, 20};
    set_cfg(10, 20, 4, 1);
    do_load(8'd10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      do_step();
      total++;
      if (int'(address) !== ea[k] || wrapped !== (k == 2) || done !== (k == 2)) begin
        bad++;
        $display("FAIL stop_walk[%0d]: got addr=%0d wrapped=%0b done=%0b expected %0d %0b %0b",
                 k, address, wrapped, done, ea[k], k == 2, k == 2);
      end
    end
    for (int k = 0; k < 2; k++) begin
      do_step();
      total++;
      if (address !== 8'd20 || wrapped !== 1'b0 || done !== 1'b1) begin
        bad++;
        $display("FAIL stop_hold[%0d]: got addr=%0d wrapped=%0b done=%0b expected 20 0 1",
                 k, address, wrapped, done);
      end
    end
    mode = 2'd0;
    do_step();
    total++;
    if (address !== 8'd20 || done !== 1'b1) begin
      bad++; $display("FAIL stop_mode_change: got addr=%0d done=%0b expected 20 1", address, done);
    end
    do_load(8'd12, 1'b0);
    total++;
    if (address !== 8'd12 || done !== 1'b0) begin
      bad++; $display("FAIL stop_reload: got addr=%0d done=%0b expected 12 0", address, done);
    end
  endtask

  task automatic test_pingpong();
    int ea[7] = '{19, 20, 17, 14, 11, 10, 13};
    int ed[7] = '{0, 1, 1, 1, 1, 0, 0};
    int ew[7] = '{0, 1, 0, 0, 0, 1, 0};
    set_cfg(10, 20, 3, 2);
    do_load(8'd16, 1'b0);
    for (int k = 0; k < 7; k++) begin
      do_step();
      total++;
      if (int'(address) !== ea[k] || int'(dir) !== ed[k] || int'(wrapped) !== ew[k]) begin
        bad++;
        $display("FAIL ping[%0d]: got addr=%0d dir=%0b wrapped=%0b expected %0d %0d %0d",
                 k, address, dir, wrapped, ea[k], ed[k], ew[k]);
      end
    end
  endtask

  task automatic test_down_wrap();
    set_cfg(0, 7, 2, 0);
    do_load(8'd1, 1'b1);
    do_step();
    total++;
    if (address !== 8'd7 || wrapped !== 1'b1 || dir !== 1'b1) begin
      bad++;
      $display("FAIL down_borrow: got addr=%0d wrapped=%0b dir=%0b expected 7 1 1",
               address, wrapped, dir);
    end
  endtask

  task automatic test_ignored();
    set_cfg(0, 100, 3, 0);
    do_load(8'd45, 1'b0);
    set_cfg(50, 40, 3, 0);
    #1;
    total++;
    if (cfg_err !== 1'b1) begin
      bad++; $display("FAIL cfg_err_set: got %0b expected 1", cfg_err);
    end
    do_step();
    total++;
    if (address !== 8'd45 || wrapped !== 1'b0) begin
      bad++; $display("FAIL cfg_err_step: got addr=%0d wrapped=%0b expected 45 0", address, wrapped);
    end
    set_cfg(0, 100, 0, 0);
    #1;
    total++;
    if (cfg_err !== 1'b0) begin
      bad++; $display("FAIL cfg_err_clear: got %0b expected 0", cfg_err);
    end
    do_step();
    total++;
    if (address !== 8'd45) begin
      bad++; $display("FAIL stride0_step: got %0d expected 45", address);
    end
    set_cfg(0, 100, 3, 3);
    do_step();
    total++;
    if (address !== 8'd45) begin
      bad++; $display("FAIL hold_step: got %0d expected 45", address);
    end
    mode = 2'd0;
    do_step();
    total++;
    if (address !== 8'd48) begin
      bad++; $display("FAIL resume_step: got %0d expected 48", address);
    end
  endtask

  task automatic test_priority();
    set_cfg(0, 255, 1, 0);
    load_addr = 8'd5;
    dir_init  = 1'b0;
    load      = 1'b1;
    step      = 1'b1;
    cycle();
    load      = 1'b0;
    step      = 1'b0;
    total++;
    if (address !== 8'd5) begin
      bad++; $display("FAIL load_over_step: got %0d expected 5", address);
    end
    load_addr = 8'd9;
    load      = 1'b1;
    reset     = 1'b1;
    cycle();
    load      = 1'b0;
    reset     = 1'b0;
    total++;
    if (address !== 8'd0) begin
      bad++; $display("FAIL reset_over_load: got %0d expected 0", address);
    end
  endtask

  task automatic test_random();
    int r, lo, hi;
    for (int i = 0; i < 3000; i++) begin
      if (i % 20 == 0) begin
        r = $urandom_range(0, 9);
        lo = $urandom_range(0, 230);
        hi = lo + $urandom_range(0, 25);
        if (r == 0) begin
          lo = 0; hi = 255;
        end else if (r == 1) begin
          hi = lo;
        end else if (r == 2) begin
          hi = lo; lo = lo + $urandom_range(1, 20);
        end else if (r == 3) begin
          lo = $urandom_range(220, 250); hi = 255;
        end
        set_cfg(lo, hi, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15),
                $urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      reset     = ($urandom_range(0, 199) == 0);
      load      = ($urandom_range(0, 11) == 0);
      step      = ($urandom_range(0, 1) == 1);
      load_addr = 8'($urandom_range(0, 255));
      dir_init  = 1'($urandom_range(0, 1));
      cycle();
      total++;
      if (int'(address) !== m_a || int'(dir) !== m_d || int'(wrapped) !== m_w ||
          int'(done) !== m_h || int'(cfg_err) !== int'(lo_bound > hi_bound)) begin
        bad++;
        $display("FAIL random[%0d]: got addr=%0d dir=%0b wr=%0b done=%0b cerr=%0b expected %0d %0d %0d %0d %0b",
                 i, address, dir, wrapped, done, cfg_err, m_a, m_d, m_w, m_h,
                 lo_bound > hi_bound);
      end
    end
    reset = 1'b0;
    load  = 1'b0;
    step  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_full();
    test_stop();
    test_pingpong();
    test_down_wrap();
    test_ignored();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
